// File: rtl/tl_ul_master_adapter_if.sv
// TL-UL Channel A/D bundle between a master adapter and the fabric.
// The master drives Channel A and d_ready; the slave drives a_ready and Channel D.
interface tl_ul_master_adapter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SOURCE_WIDTH = 2,
  parameter int SINK_WIDTH   = 1,
  parameter int SIZE_WIDTH   = 3
);
  logic [2:0]              a_opcode;
  logic [2:0]              a_param;
  logic [SIZE_WIDTH-1:0]   a_size;
  logic [SOURCE_WIDTH-1:0] a_source;
  logic [ADDR_WIDTH-1:0]   a_address;
  logic [DATA_WIDTH/8-1:0] a_mask;
  logic [DATA_WIDTH-1:0]   a_data;
  logic                    a_corrupt;
  logic                    a_valid;
  logic                    a_ready;

  logic [2:0]              d_opcode;
  logic [1:0]              d_param;
  logic [SIZE_WIDTH-1:0]   d_size;
  logic [SOURCE_WIDTH-1:0] d_source;
  logic [SINK_WIDTH-1:0]   d_sink;
  logic                    d_denied;
  logic [DATA_WIDTH-1:0]   d_data;
  logic                    d_corrupt;
  logic                    d_valid;
  logic                    d_ready;

  modport master (
    output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
    input  a_ready,
    input  d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
    output d_ready
  );

  modport slave (
    input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
    output a_ready,
    output d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
    input  d_ready
  );
endinterface

// File: rtl/tl_ul_master_adapter.sv
// Core load/store -> TL-UL Get/Put master with one outstanding transaction per source ID.
// Request to a_valid and D beat to rsp_valid are 1 cycle; req_ready drops when no source is free or A is stalled.
module tl_ul_master_adapter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SOURCE_WIDTH = 2,
  parameter int SINK_WIDTH   = 1,
  parameter int SIZE_WIDTH   = 3
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic                      req_we,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_be,
  input  logic [SIZE_WIDTH-1:0]     req_size,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_we,
  output logic [SOURCE_WIDTH-1:0]   rsp_source,

  tl_ul_master_adapter_if.master    tl,

  output logic [SOURCE_WIDTH:0]     outstanding_cnt,
  output logic                      idle
);

  localparam int NSRC      = 1 << SOURCE_WIDTH;
  localparam int MASK_W    = DATA_WIDTH / 8;
  localparam int FULL_SIZE = $clog2(MASK_W);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  logic [2:0]              a_opcode_q,  a_opcode_d;
  logic [SIZE_WIDTH-1:0]   a_size_q,    a_size_d;
  logic [SOURCE_WIDTH-1:0] a_source_q,  a_source_d;
  logic [ADDR_WIDTH-1:0]   a_address_q, a_address_d;
  logic [MASK_W-1:0]       a_mask_q,    a_mask_d;
  logic [DATA_WIDTH-1:0]   a_data_q,    a_data_d;
  logic                    a_valid_q,   a_valid_d;

  logic                    rsp_valid_q,  rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q,  rsp_rdata_d;
  logic                    rsp_err_q,    rsp_err_d;
  logic                    rsp_we_q,     rsp_we_d;
  logic [SOURCE_WIDTH-1:0] rsp_source_q, rsp_source_d;

  logic [NSRC-1:0]         busy_q, busy_d;
  logic [SOURCE_WIDTH:0]   cnt_q,  cnt_d;

  logic [SOURCE_WIDTH-1:0] free_id;
  logic                    any_free;
  logic                    accept;
  logic                    a_fire;
  logic                    d_ready;
  logic                    d_fire;
  logic                    src_busy;
  logic                    full_put;
  logic                    bad_opcode;
  logic                    unused_d;

  // Lowest-numbered free source wins; scanning downward leaves the smallest index last.
  always_comb begin
    free_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_id = SOURCE_WIDTH'(i);
      end
    end
  end

  assign any_free   = |(~busy_q);
  assign req_ready  = any_free && (!a_valid_q || tl.a_ready);
  assign accept     = req_valid && req_ready;
  assign a_fire     = a_valid_q && tl.a_ready;
  assign d_ready    = !rsp_valid_q || rsp_ready;
  assign d_fire     = tl.d_valid && d_ready;
  assign src_busy   = busy_q[tl.d_source];
  assign full_put   = (&req_be) && (req_size == SIZE_WIDTH'(FULL_SIZE));
  assign bad_opcode = (tl.d_opcode != OP_ACK) && (tl.d_opcode != OP_ACK_DATA);
  assign unused_d   = ^{tl.d_param, tl.d_size, tl.d_sink};

  always_comb begin
    a_valid_d   = a_valid_q;
    a_opcode_d  = a_opcode_q;
    a_size_d    = a_size_q;
    a_source_d  = a_source_q;
    a_address_d = a_address_q;
    a_mask_d    = a_mask_q;
    a_data_d    = a_data_q;
    if (accept) begin
      a_valid_d   = 1'b1;
      a_source_d  = free_id;
      a_address_d = req_addr;
      a_size_d    = req_size;
      a_mask_d    = req_be;
      if (!req_we) begin
        a_opcode_d = OP_GET;
        a_data_d   = '0;
      end else begin
        a_opcode_d = full_put ? OP_PUT_FULL : OP_PUT_PARTIAL;
        a_data_d   = req_wdata;
      end
    end else if (a_fire) begin
      a_valid_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    rsp_we_d     = rsp_we_q;
    rsp_source_d = rsp_source_q;
    if (d_fire) begin
      rsp_valid_d  = 1'b1;
      rsp_source_d = tl.d_source;
      rsp_we_d     = (tl.d_opcode == OP_ACK);
      rsp_rdata_d  = (tl.d_opcode == OP_ACK_DATA) ? tl.d_data : '0;
      rsp_err_d    = tl.d_denied | tl.d_corrupt | bad_opcode | !src_busy;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Free before allocate: a stray D beat to the source being handed out must not cancel it.
  always_comb begin
    busy_d = busy_q;
    if (d_fire) begin
      busy_d[tl.d_source] = 1'b0;
    end
    if (accept) begin
      busy_d[free_id] = 1'b1;
    end
    cnt_d = cnt_q + (SOURCE_WIDTH+1)'(accept) - (SOURCE_WIDTH+1)'(d_fire && src_busy);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q    <= 1'b0;
      a_opcode_q   <= '0;
      a_size_q     <= '0;
      a_source_q   <= '0;
      a_address_q  <= '0;
      a_mask_q     <= '0;
      a_data_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_we_q     <= 1'b0;
      rsp_source_q <= '0;
      busy_q       <= '0;
      cnt_q        <= '0;
    end else begin
      a_valid_q    <= a_valid_d;
      a_opcode_q   <= a_opcode_d;
      a_size_q     <= a_size_d;
      a_source_q   <= a_source_d;
      a_address_q  <= a_address_d;
      a_mask_q     <= a_mask_d;
      a_data_q     <= a_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      rsp_we_q     <= rsp_we_d;
      rsp_source_q <= rsp_source_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign tl.a_valid   = a_valid_q;
  assign tl.a_opcode  = a_opcode_q;
  assign tl.a_param   = 3'b000;
  assign tl.a_size    = a_size_q;
  assign tl.a_source  = a_source_q;
  assign tl.a_address = a_address_q;
  assign tl.a_mask    = a_mask_q;
  assign tl.a_data    = a_data_q;
  assign tl.a_corrupt = 1'b0;
  assign tl.d_ready   = d_ready;

  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_we          = rsp_we_q;
  assign rsp_source      = rsp_source_q;
  assign outstanding_cnt = cnt_q;
  assign idle            = (cnt_q == '0) && !a_valid_q && !rsp_valid_q;

  logic [ADDR_WIDTH-1:0] align_mask;
  assign align_mask = (ADDR_WIDTH'(1) << req_size) - ADDR_WIDTH'(1);

  a_req_size_ok: assert property (@(posedge clk) disable iff (rst)
    accept |-> (req_size <= SIZE_WIDTH'(FULL_SIZE)));

  a_req_aligned: assert property (@(posedge clk) disable iff (rst)
    accept |-> ((req_addr & align_mask) == '0));

  a_cnt_matches_busy: assert property (@(posedge clk) disable iff (rst)
    $countones(busy_q) == int'(cnt_q));

endmodule

// File: tb/tb_tl_ul_master_adapter.sv
// Bench for tl_ul_master_adapter: directed scenarios then random traffic, all checked
// against a transaction-level model of source allocation, Channel A contents and responses.
module tb_tl_ul_master_adapter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 2;
  localparam int KW = 1;
  localparam int ZW = 3;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic [2:0]    req_size;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_we;
  logic [SW-1:0] rsp_source;
  logic [SW:0]   outstanding_cnt;
  logic          idle;

  always #5 clk = ~clk;

  tl_ul_master_adapter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SOURCE_WIDTH(SW),
                            .SINK_WIDTH(KW), .SIZE_WIDTH(ZW)) tl ();

  tl_ul_master_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SOURCE_WIDTH(SW),
                         .SINK_WIDTH(KW), .SIZE_WIDTH(ZW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .req_be(req_be), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_we(rsp_we), .rsp_source(rsp_source),
    .tl(tl),
    .outstanding_cnt(outstanding_cnt), .idle(idle)
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  src;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [2:0]  size;
  } a_txn_t;

  typedef struct {
    logic [1:0]  src;
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } r_txn_t;

  bit     mbusy [NS];
  int     mcnt;
  bit     ma_vld;
  a_txn_t ma;
  bit     mr_vld;
  r_txn_t mr;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < NS; i++) begin
      if (!mbusy[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mbusy[i] = 1'b0;
    mcnt   = 0;
    ma_vld = 1'b0;
    mr_vld = 1'b0;
  endtask

  task automatic check_state();
    chk("a_valid", 64'(tl.a_valid), 64'(ma_vld));
    if (ma_vld) begin
      chk("a_opcode",  64'(tl.a_opcode),  64'(ma.op));
      chk("a_source",  64'(tl.a_source),  64'(ma.src));
      chk("a_address", 64'(tl.a_address), 64'(ma.addr));
      chk("a_mask",    64'(tl.a_mask),    64'(ma.mask));
      chk("a_data",    64'(tl.a_data),    64'(ma.data));
      chk("a_size",    64'(tl.a_size),    64'(ma.size));
      chk("a_param",   64'(tl.a_param),   64'(0));
      chk("a_corrupt", 64'(tl.a_corrupt), 64'(0));
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(mr_vld));
    if (mr_vld) begin
      chk("rsp_source", 64'(rsp_source), 64'(mr.src));
      chk("rsp_we",     64'(rsp_we),     64'(mr.we));
      chk("rsp_rdata",  64'(rsp_rdata),  64'(mr.rdata));
      chk("rsp_err",    64'(rsp_err),    64'(mr.err));
    end
    chk("outstanding_cnt", 64'(outstanding_cnt), 64'(mcnt));
    chk("idle", 64'(idle), 64'(mcnt == 0 && !ma_vld && !mr_vld));
  endtask

  // Inputs are already driven; predict handshakes, advance the model, clock once, compare.
  task automatic tick();
    int lf;
    bit pr_rr;
    bit pr_dr;
    bit acc;
    bit dfire;
    #1;
    lf    = lowest_free();
    pr_rr = (lf >= 0) && (!ma_vld || tl.a_ready);
    pr_dr = !mr_vld || rsp_ready;
    chk("req_ready", 64'(req_ready), 64'(pr_rr));
    chk("d_ready",   64'(tl.d_ready), 64'(pr_dr));
    acc   = req_valid && pr_rr;
    dfire = tl.d_valid && pr_dr;
    if (acc) begin
      ma.src  = 2'(lf);
      ma.addr = req_addr;
      ma.mask = req_be;
      ma.size = req_size;
      ma.op   = !req_we ? 3'd4 : ((req_be == 4'hF && req_size == 3'd2) ? 3'd0 : 3'd1);
      ma.data = req_we ? req_wdata : 32'h0;
      ma_vld  = 1'b1;
    end else if (ma_vld && tl.a_ready) begin
      ma_vld = 1'b0;
    end
    if (dfire) begin
      mr.src   = tl.d_source;
      mr.we    = (tl.d_opcode == 3'd0);
      mr.rdata = (tl.d_opcode == 3'd1) ? tl.d_data : 32'h0;
      mr.err   = tl.d_denied | tl.d_corrupt | (tl.d_opcode > 3'd1) | !mbusy[tl.d_source];
      mr_vld   = 1'b1;
      if (mbusy[tl.d_source]) begin
        mbusy[tl.d_source] = 1'b0;
        mcnt--;
      end
    end else if (mr_vld && rsp_ready) begin
      mr_vld = 1'b0;
    end
    if (acc) begin
      mbusy[lf] = 1'b1;
      mcnt++;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle_in();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; req_size = '0;
    rsp_ready = 1'b1;
    tl.a_ready = 1'b1;
    tl.d_valid = 1'b0; tl.d_opcode = '0; tl.d_param = '0; tl.d_size = '0; tl.d_source = '0;
    tl.d_sink = '0; tl.d_denied = 1'b0; tl.d_data = '0; tl.d_corrupt = 1'b0;
  endtask

  task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [2:0] size);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_size = size;
  endtask

  task automatic set_d(input logic [2:0] op, input logic [1:0] src, input logic [31:0] data,
                       input logic den, input logic cor);
    tl.d_valid = 1'b1; tl.d_opcode = op; tl.d_source = src; tl.d_data = data;
    tl.d_denied = den; tl.d_corrupt = cor; tl.d_size = 3'd2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst a_valid",    64'(tl.a_valid),    64'(0));
    chk("rst a_opcode",   64'(tl.a_opcode),   64'(0));
    chk("rst a_source",   64'(tl.a_source),   64'(0));
    chk("rst a_address",  64'(tl.a_address),  64'(0));
    chk("rst a_mask",     64'(tl.a_mask),     64'(0));
    chk("rst a_data",     64'(tl.a_data),     64'(0));
    chk("rst a_size",     64'(tl.a_size),     64'(0));
    chk("rst rsp_valid",  64'(rsp_valid),     64'(0));
    chk("rst rsp_rdata",  64'(rsp_rdata),     64'(0));
    chk("rst rsp_err",    64'(rsp_err),       64'(0));
    chk("rst rsp_we",     64'(rsp_we),        64'(0));
    chk("rst rsp_source", 64'(rsp_source),    64'(0));
    chk("rst cnt",        64'(outstanding_cnt), 64'(0));
    chk("rst idle",       64'(idle),          64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    #2;
    do_reset();

    // Read then AccessAckData
    set_req(1'b0, 32'h1000, 32'h0, 4'hF, 3'd2); tick();
    chk("rd a_opcode", 64'(tl.a_opcode), 64'(4));
    chk("rd a_source", 64'(tl.a_source), 64'(0));
    chk("rd a_mask",   64'(tl.a_mask),   64'(4'hF));
    req_valid = 1'b0; tick();
    set_d(3'd1, 2'd0, 32'hDEADBEEF, 1'b0, 1'b0); tick();
    chk("rd rsp_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    chk("rd rsp_err",   64'(rsp_err),   64'(0));
    chk("rd rsp_we",    64'(rsp_we),    64'(0));
    tl.d_valid = 1'b0; tick();

    // Full and partial puts
    set_req(1'b1, 32'h2000, 32'h11223344, 4'hF, 3'd2); tick();
    chk("putfull opcode", 64'(tl.a_opcode), 64'(0));
    set_req(1'b1, 32'h2002, 32'h00005566, 4'h3, 3'd1); tick();
    chk("putpart opcode", 64'(tl.a_opcode), 64'(1));
    chk("putpart data",   64'(tl.a_data),   64'(32'h5566));
    chk("putpart source", 64'(tl.a_source), 64'(1));
    req_valid = 1'b0; tick();
    set_d(3'd0, 2'd0, 32'h0, 1'b0, 1'b0); tick();
    chk("ack rsp_we",    64'(rsp_we),    64'(1));
    chk("ack rsp_rdata", 64'(rsp_rdata), 64'(0));
    set_d(3'd0, 2'd1, 32'h0, 1'b0, 1'b0); tick();
    tl.d_valid = 1'b0; tick();

    // Fill every source, then free source 2 and reuse it
    for (int i = 0; i < NS; i++) begin
      set_req(1'b0, 32'h3000 + 32'(i * 4), 32'h0, 4'hF, 3'd2); tick();
      chk("fill a_source", 64'(tl.a_source), 64'(i));
    end
    chk("full req_ready", 64'(req_ready), 64'(0));
    chk("full cnt",       64'(outstanding_cnt), 64'(4));
    tick();
    set_d(3'd1, 2'd2, 32'hCAFE0002, 1'b0, 1'b0); tick();
    tl.d_valid = 1'b0; tick();
    chk("reuse a_source", 64'(tl.a_source), 64'(2));
    req_valid = 1'b0; tick();
    for (int s = 0; s < NS; s++) begin
      set_d(3'd1, 2'(s), 32'h100 + 32'(s), 1'b0, 1'b0); tick();
    end
    tl.d_valid = 1'b0; tick();

    // Channel A stall holds the request stable and blocks the core
    tl.a_ready = 1'b0;
    set_req(1'b1, 32'h4000, 32'hA5A5A5A5, 4'h6, 3'd2); tick();
    set_req(1'b1, 32'h4004, 32'h5A5A5A5A, 4'hF, 3'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall req_ready", 64'(req_ready),    64'(0));
      chk("stall a_address", 64'(tl.a_address), 64'(32'h4000));
    end
    req_valid = 1'b0; tl.a_ready = 1'b1; tick();
    tick();
    chk("no dup a_valid", 64'(tl.a_valid), 64'(0));
    set_d(3'd0, 2'd0, 32'h0, 1'b0, 1'b0); tick();
    tl.d_valid = 1'b0; tick();

    // Denied response and a response for a source that is not busy
    set_req(1'b0, 32'h5000, 32'h0, 4'hF, 3'd2); tick();
    set_req(1'b0, 32'h5004, 32'h0, 4'hF, 3'd2); tick();
    req_valid = 1'b0; tick();
    set_d(3'd1, 2'd1, 32'h12345678, 1'b1, 1'b0); tick();
    chk("denied rsp_err", 64'(rsp_err), 64'(1));
    chk("denied cnt",     64'(outstanding_cnt), 64'(1));
    set_d(3'd0, 2'd3, 32'h0, 1'b0, 1'b0); tick();
    chk("stray rsp_err", 64'(rsp_err), 64'(1));
    chk("stray cnt",     64'(outstanding_cnt), 64'(1));
    tl.d_valid = 1'b0; tick();

    // Response backpressure holds Channel D
    set_req(1'b0, 32'h6000, 32'h0, 4'hF, 3'd2); tick();
    req_valid = 1'b0; tick();
    rsp_ready = 1'b0;
    set_d(3'd1, 2'd0, 32'h0BADF00D, 1'b0, 1'b0); tick();
    set_d(3'd1, 2'd1, 32'h600D600D, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("bp d_ready",   64'(tl.d_ready), 64'(0));
      chk("bp rsp_rdata", 64'(rsp_rdata),  64'(32'h0BADF00D));
    end
    rsp_ready = 1'b1; tick();
    chk("bp released rdata", 64'(rsp_rdata), 64'(32'h600D600D));
    tl.d_valid = 1'b0; tick();

    // Reset with two transactions outstanding
    set_req(1'b0, 32'h7000, 32'h0, 4'hF, 3'd2); tick();
    set_req(1'b0, 32'h7004, 32'h0, 4'hF, 3'd2); tick();
    req_valid = 1'b0; tick();
    chk("pre-reset cnt", 64'(outstanding_cnt), 64'(2));
    idle_in();
    do_reset();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      int s;
      req_valid = ($urandom_range(0, 2) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_size  = 3'($urandom_range(0, 2));
      req_addr  = $urandom & ~((32'h1 << req_size) - 32'h1);
      req_be    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      req_wdata = $urandom;
      tl.a_ready = ($urandom_range(0, 3) != 0);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      s = $urandom_range(0, NS - 1);
      if (mbusy[s] && !(ma_vld && ma.src == 2'(s)) && $urandom_range(0, 1) == 1) begin
        set_d(3'($urandom_range(0, 2)), 2'(s), $urandom,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end else begin
        tl.d_valid = 1'b0;
      end
      tick();
    end

    // Drain everything outstanding
    idle_in();
    tick();
    tick();
    for (int s = 0; s < NS; s++) begin
      if (mbusy[s]) begin
        set_d(3'd1, 2'(s), 32'h0, 1'b0, 1'b0); tick();
      end
    end
    tl.d_valid = 1'b0;
    tick();
    tick();
    chk("drain idle", 64'(idle), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
